mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares one bus master port between instruction fetch (I) and data memory access (D).
// - Sequences each access as a bus handshake and sends stall requests to the pipeline controller.
// - Holds returned data while the pipeline is held, and discards in-flight data on a flush.
// PARAMETERS
// - ADDR_W          32   address width
// - DATA_W          32   data width; sel width = DATA_W/8
// - TIMEOUT_CYCLES  255  max cycles without ack before abort (MEM_ARB_TIMEOUT_EN only)
// PORTS
// - clk           in   1       clock, rising edge
// - rst           in   1       reset, synchronous, active-high
// - flush         in   1       pipeline flush (exception/eret)
// - if_req        in   1       fetch request
// - if_addr       in   ADDR_W  fetch address
// - if_hold       in   1       fetch stage held by ctrl
// - if_rdata      out  DATA_W  fetched instruction
// - if_stallreq   out  1       fetch stall request to ctrl
// - mem_req       in   1       load/store request
// - mem_we        in   1       1=store
// - mem_sel       in   DATA_W/8  byte enables
// - mem_addr      in   ADDR_W  data address
// - mem_wdata     in   DATA_W  store data
// - mem_hold      in   1       MEM stage held by ctrl
// - mem_rdata     out  DATA_W  load data
// - mem_stallreq  out  1       MEM stall request to ctrl
// - bus_cyc/bus_stb  out  1    cycle/strobe, always driven equal
// - bus_we        out  1       write enable
// - bus_sel       out  DATA_W/8  byte enables
// - bus_addr      out  ADDR_W  address
// - bus_wdata     out  DATA_W  write data
// - bus_rdata     in   DATA_W  slave read data
// - bus_ack       in   1       slave ack; valid only while bus_stb=1
// - if_err/mem_err  out  1     bus-timeout pulse (MEM_ARB_TIMEOUT_EN only)
// BEHAVIOUR
// - States: IDLE, XFER_I, XFER_D, DONE_I, DONE_D, DRAIN.
// - Reset: state IDLE. All bus_*, if_rdata, mem_rdata and err outputs are 0.
// - IDLE arbitration: mem_req beats if_req (older instruction). No grant while flush=1.
//   - On a grant, latch that port's request into the bus_* registers.
//   - Go to XFER_D or XFER_I; bus_stb=1 from the next cycle.
// - XFER_x: bus_* held stable until bus_ack=1 is sampled. On ack:
//   - bus_cyc/stb/we/sel go to 0 next cycle.
//   - bus_rdata is captured into the port's rdata register; go to DONE_x.
//   - Writes also capture bus_rdata; the value is don't-care.
// - DONE_x: port data valid and that port's stallreq=0.
//   - Stay in DONE_x while x_hold=1; rdata stays stable and no new bus cycle starts.
//   - Go to IDLE when x_hold=0.
// - Latency: zero-wait slave (ack in the first stb cycle) gives data in cycle 2 after the request.
//   - Each wait state adds one cycle.
// - x_stallreq = x_req & ~flush & (state != DONE_x). The port not being served stalls while the other port transfers.
// - flush while in XFER_x: go to DRAIN; the bus cycle completes and is never aborted.
// - DRAIN: on ack, discard the data (rdata registers unchanged) and go to IDLE.
// - flush while in DONE_x: go to IDLE. flush while in IDLE: no grant.
// - rst while in any state: go to IDLE next cycle and drop bus_cyc/stb immediately.
// - Simultaneous flush and ack in XFER_x: the data is discarded; go to IDLE.
// CONFIGURATION
// - MEM_ARB_TIMEOUT_EN defined:
//   - A counter clears on entering XFER_x/DRAIN and increments each cycle without ack.
//   - When it reaches TIMEOUT_CYCLES: drop cyc/stb, load rdata with 0, pulse x_err for 1 cycle, go to DONE_x.
//   - From DRAIN, go to IDLE with no err pulse.
// - MEM_ARB_TIMEOUT_EN undefined:
//   - No counter and no err ports; the arbiter waits for ack indefinitely.
// STRUCTURE
// - Shared defines/package: state encodings, RstEnable, Stop, bus widths, ZeroWord.
// - Sub-module arb_timeout_cnt: counter plus compare, instantiated only under MEM_ARB_TIMEOUT_EN.
// - Next-state logic and all registers live in mem_bus_arbiter.
// TESTING
// - Reset: rst=1 for 2 cycles -> bus_cyc=0, rdata=0, stallreqs=0.
// - Fetch 0x00000100, slave acks after 2 wait states with 0x24020005:
//   - if_stallreq=1 in cycles 0-3 and bus_stb=1 in cycles 1-3.
//   - Cycle 4: if_rdata=0x24020005 and if_stallreq=0.
// - if_req and mem_req (store 0x80, sel=F, wdata=0xDEADBEEF) in the same cycle:
//   - D is served first with bus_we=1; if_stallreq stays 1.
//   - I is granted after DONE_D->IDLE.
// - flush=1 for one cycle during XFER_I: bus_stb is held until ack, if_rdata is unchanged, state returns to IDLE.
// - mem_hold=1 for 3 cycles in DONE_D: mem_rdata is stable, bus_cyc=0, if_req is not granted until hold=0.
// - With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack:
//   - bus_cyc falls after 8 cycles.
//   - mem_err pulses once and mem_rdata=0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared constants for the memory bus arbiter: FSM state
//               encodings, reset/stall polarities and default bus widths.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    // Default bus geometry
    localparam int c_BUS_ADDR_W = 32;
    localparam int c_BUS_DATA_W = 32;

    // Polarities
    localparam logic c_RST_ENABLE = 1'b1;
    localparam logic c_STOP       = 1'b1;

    // Arbiter FSM encodings
    localparam int         c_ST_W      = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_XFER_I = 3'd1;
    localparam logic [2:0] c_ST_XFER_D = 3'd2;
    localparam logic [2:0] c_ST_DONE_I = 3'd3;
    localparam logic [2:0] c_ST_DONE_D = 3'd4;
    localparam logic [2:0] c_ST_DRAIN  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/arb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : arb_timeout_cnt
// Description : Bus-cycle watchdog for the arbiter. Counts strobe cycles
//               that pass without an ack and flags expiry on the cycle that
//               would be the TIMEOUT_CYCLES-th ack-less strobe cycle.
//               Only built when MEM_ARB_TIMEOUT_EN is defined.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_clr         - restart count (entering a wait state)
//               i_run         - a bus cycle is outstanding
//               i_ack         - slave ack
//               o_expire      - timeout reached this cycle
// Revision    : 1.0  initial release
// ============================================================================
`ifdef MEM_ARB_TIMEOUT_EN
module arb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expire
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // r_cnt is the number of ack-less strobe cycles already completed,
    // so the current cycle is number r_cnt+1.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_run && !i_ack && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_run && !i_ack && (r_cnt == c_LAST);

endmodule
`endif
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one bus master port between instruction fetch (I)
//               and data access (D). Data wins arbitration. Each access is
//               one cyc/stb/ack handshake; returned data is held while the
//               requesting stage is held, and discarded after a flush.
//               Optional bus watchdog: define MEM_ARB_TIMEOUT_EN to add the
//               TIMEOUT_CYCLES parameter and the if_err/mem_err ports.
// Ports       : clk/rst                 - clock, sync active-high reset
//               flush                   - pipeline flush
//               if_req/if_addr/if_hold  - fetch request side
//               if_rdata/if_stallreq    - fetch data / stall request
//               mem_req/we/sel/addr/wdata/hold - data request side
//               mem_rdata/mem_stallreq  - load data / stall request
//               bus_cyc/stb/we/sel/addr/wdata  - bus master outputs
//               bus_rdata/bus_ack       - bus slave response
//               if_err/mem_err          - timeout pulses (watchdog build)
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_BUS_ADDR_W,
    parameter int DATA_W = c_BUS_DATA_W
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_hold,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stallreq,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_hold,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_stallreq,
    output logic                bus_cyc,
    output logic                bus_stb,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                if_err,
    output logic                mem_err
`endif
);

    localparam int SEL_W = DATA_W / 8;

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_next_state;

    logic              r_bus_cyc;
    logic              r_bus_we;
    logic [SEL_W-1:0]  r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;

    logic w_grant_d;
    logic w_grant_i;
    logic w_in_xfer;
    logic w_bus_end;
    logic w_timeout;

    // Grants are only issued from IDLE and never during a flush; the data
    // side belongs to the older instruction so it takes priority.
    assign w_grant_d = (r_state == c_ST_IDLE) && !flush && mem_req;
    assign w_grant_i = (r_state == c_ST_IDLE) && !flush && !mem_req && if_req;

    // A bus cycle is outstanding in XFER_I, XFER_D and DRAIN.
    assign w_in_xfer = (r_state == c_ST_XFER_I) || (r_state == c_ST_XFER_D) ||
                       (r_state == c_ST_DRAIN);
    assign w_bus_end = bus_ack || w_timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_enter_wait;
    logic r_if_err;
    logic r_mem_err;

    // Restart the watchdog whenever a wait state is newly entered,
    // including XFER_x -> DRAIN.
    assign w_enter_wait = (w_next_state != r_state) &&
                          ((w_next_state == c_ST_XFER_I) ||
                           (w_next_state == c_ST_XFER_D) ||
                           (w_next_state == c_ST_DRAIN));

    arb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_enter_wait),
        .i_run    (w_in_xfer),
        .i_ack    (bus_ack),
        .o_expire (w_timeout)
    );

    // Error pulses only for a live transfer; a drained or flushed cycle
    // that times out is dropped silently.
    always_ff @(posedge clk) begin
        if (rst == c_RST_ENABLE) begin
            r_if_err  <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            r_if_err  <= (r_state == c_ST_XFER_I) && !flush && !bus_ack && w_timeout;
            r_mem_err <= (r_state == c_ST_XFER_D) && !flush && !bus_ack && w_timeout;
        end
    end

    assign if_err  = r_if_err;
    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == c_RST_ENABLE) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = c_ST_XFER_D;
                end else if (w_grant_i) begin
                    w_next_state = c_ST_XFER_I;
                end
            end
            c_ST_XFER_I: begin
                // A flushed cycle still has to finish on the bus; if it
                // finishes in the flush cycle itself there is nothing to drain.
                if (flush) begin
                    w_next_state = w_bus_end ? c_ST_IDLE : c_ST_DRAIN;
                end else if (w_bus_end) begin
                    w_next_state = c_ST_DONE_I;
                end
            end
            c_ST_XFER_D: begin
                if (flush) begin
                    w_next_state = w_bus_end ? c_ST_IDLE : c_ST_DRAIN;
                end else if (w_bus_end) begin
                    w_next_state = c_ST_DONE_D;
                end
            end
            c_ST_DONE_I: begin
                if (flush || !if_hold) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_DONE_D: begin
                if (flush || !mem_hold) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_DRAIN: begin
                if (w_bus_end) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        if_stallreq  = (if_req && !flush && (r_state != c_ST_DONE_I)) ? c_STOP : ~c_STOP;
        mem_stallreq = (mem_req && !flush && (r_state != c_ST_DONE_D)) ? c_STOP : ~c_STOP;
        // Reset removes the strobe in the same cycle rather than at the
        // next edge, so a slave never sees a half-abandoned cycle.
        bus_cyc      = r_bus_cyc && (rst != c_RST_ENABLE);
        bus_stb      = r_bus_cyc && (rst != c_RST_ENABLE);
    end

    assign bus_we    = r_bus_we;
    assign bus_sel   = r_bus_sel;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;

    // ------------------------------------------------------------------
    // Bus request registers and returned-data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == c_RST_ENABLE) begin
            r_bus_cyc   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (w_grant_d) begin
                r_bus_cyc   <= 1'b1;
                r_bus_we    <= mem_we;
                r_bus_sel   <= mem_sel;
                r_bus_addr  <= mem_addr;
                r_bus_wdata <= mem_wdata;
            end else if (w_grant_i) begin
                r_bus_cyc   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_sel   <= '1;
                r_bus_addr  <= if_addr;
                r_bus_wdata <= '0;
            end else if (w_in_xfer && w_bus_end) begin
                // Address and write data stay put; only the qualifiers drop.
                r_bus_cyc   <= 1'b0;
                r_bus_we    <= 1'b0;
                r_bus_sel   <= '0;
            end

            // Data is only kept for an unflushed transfer; a timeout
            // returns zero so the stage never consumes stale data.
            if ((r_state == c_ST_XFER_I) && !flush) begin
                if (bus_ack) begin
                    r_if_rdata <= bus_rdata;
                end else if (w_timeout) begin
                    r_if_rdata <= '0;
                end
            end
            if ((r_state == c_ST_XFER_D) && !flush) begin
                if (bus_ack) begin
                    r_mem_rdata <= bus_rdata;
                end else if (w_timeout) begin
                    r_mem_rdata <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
